// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down counter family.
// Provides the terminal-value helper and the MODULUS legality check.
`ifndef COUNTER_PKG_SV
`define COUNTER_PKG_SV

// Elaboration-time legality check; expands to a generate-if, so use it at module scope.
`define COUNTER_MODULUS_CHECK(M, W) \
    if ((W) < 1 || (W) > 31 || (M) < 2 || longint'(M) > (longint'(1) << (W))) begin : g_modulus_check \
        $error("mod_updown_counter: illegal MODULUS %0d for WIDTH %0d", (M), (W)); \
    end

package counter_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 4;
    localparam int unsigned DEFAULT_MODULUS = 16;

    // Terminal value for the current direction: maxv counting up, 0 counting down.
    function automatic int unsigned term_value(input logic up, input int unsigned maxv);
        return up ? maxv : 32'd0;
    endfunction

endpackage

`endif

// File: rtl/mod_step.sv
// Combinational next-value unit: one modulo-MODULUS step in the requested direction.
module mod_step
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned MODULUS = DEFAULT_MODULUS
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    // Explicit terminal compare keeps MODULUS == 2**WIDTH correct without relying on overflow.
    assign wrap = (count == WIDTH'(term_value(up, MODULUS - 1)));

    always_comb begin
        next_count = count;
        if (wrap) begin
            next_count = up ? '0 : MAXV;
        end else if (up) begin
            next_count = count + WIDTH'(1);
        end else begin
            next_count = count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with enable, load, clear, one-shot halt,
// terminal-count/carry outputs and a sticky load-range error flag.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             oneshot,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             carry_out,
    output logic             halted,
    output logic             err
);

    `COUNTER_MODULUS_CHECK(MODULUS, WIDTH)

    localparam logic [WIDTH-1:0] MAXV         = WIDTH'(MODULUS - 1);
    localparam bit               LOAD_CAN_ERR = longint'(MODULUS) < (longint'(1) << WIDTH);

    logic [WIDTH-1:0] next_count;
    logic             wrap;
    logic             load_over;

    mod_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_step (
        .count      (count),
        .up         (up),
        .next_count (next_count),
        .wrap       (wrap)
    );

    assign tc        = wrap;
    assign carry_out = tc & en & ~halted;
    assign load_over = LOAD_CAN_ERR && (32'(load_val) >= MODULUS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            halted <= 1'b0;
            err    <= 1'b0;
        end else if (clr) begin
            count  <= '0;
            halted <= 1'b0;
            err    <= 1'b0;
        end else if (load) begin
            count  <= load_over ? MAXV : load_val;
            halted <= 1'b0;
            if (load_over) begin
                err <= 1'b1;
            end
        end else if (en && !halted) begin
            // One-shot holds at the terminal value instead of wrapping.
            if (oneshot && tc) begin
                halted <= 1'b1;
            end else begin
                count <= next_count;
            end
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Randomised and directed check of mod_updown_counter (MODULUS 10 and 16)
// against a behavioural model.
module tb_mod_updown_counter;

    localparam int W = 4;

    int unsigned mods [2] = '{10, 16};

    logic         clk = 1'b0;
    logic         rst;
    logic         en [2], up [2], oneshot [2], clr [2], load [2];
    logic [W-1:0] load_val [2];
    logic [W-1:0] count [2];
    logic         tc [2], carry_out [2], halted [2], err [2];

    int m_cnt [2], m_halt [2], m_err [2];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(W), .MODULUS(10)) u_dec (
        .clk(clk), .rst(rst), .en(en[0]), .up(up[0]), .oneshot(oneshot[0]),
        .clr(clr[0]), .load(load[0]), .load_val(load_val[0]), .count(count[0]),
        .tc(tc[0]), .carry_out(carry_out[0]), .halted(halted[0]), .err(err[0])
    );

    mod_updown_counter #(.WIDTH(W), .MODULUS(16)) u_hex (
        .clk(clk), .rst(rst), .en(en[1]), .up(up[1]), .oneshot(oneshot[1]),
        .clr(clr[1]), .load(load[1]), .load_val(load_val[1]), .count(count[1]),
        .tc(tc[1]), .carry_out(carry_out[1]), .halted(halted[1]), .err(err[1])
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_all(input logic e, input logic u, input logic os,
                           input logic c, input logic l, input int lv);
        for (int d = 0; d < 2; d++) begin
            en[d] = e; up[d] = u; oneshot[d] = os; clr[d] = c; load[d] = l;
            load_val[d] = W'(lv);
        end
    endtask

    function automatic bit model_tc(input int d);
        return up[d] ? (m_cnt[d] == int'(mods[d]) - 1) : (m_cnt[d] == 0);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0; m_halt[d] = 0; m_err[d] = 0;
        end
    endtask

    task automatic model_edge(input int d);
        int m;
        m = int'(mods[d]);
        if (clr[d]) begin
            m_cnt[d] = 0; m_halt[d] = 0; m_err[d] = 0;
        end else if (load[d]) begin
            if (int'(load_val[d]) >= m) begin
                m_cnt[d] = m - 1;
                m_err[d] = 1;
            end else begin
                m_cnt[d] = int'(load_val[d]);
            end
            m_halt[d] = 0;
        end else if (en[d] && m_halt[d] == 0) begin
            if (oneshot[d] && model_tc(d))
                m_halt[d] = 1;
            else if (up[d])
                m_cnt[d] = (m_cnt[d] + 1) % m;
            else
                m_cnt[d] = (m_cnt[d] + m - 1) % m;
        end
    endtask

    task automatic check_regs();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("count[m%0d]", mods[d]),  32'(count[d]),  32'(m_cnt[d]));
            check($sformatf("halted[m%0d]", mods[d]), 32'(halted[d]), 32'(m_halt[d]));
            check($sformatf("err[m%0d]", mods[d]),    32'(err[d]),    32'(m_err[d]));
        end
    endtask

    task automatic check_comb();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("tc[m%0d]", mods[d]), 32'(tc[d]), 32'(model_tc(d)));
            check($sformatf("carry_out[m%0d]", mods[d]), 32'(carry_out[d]),
                  32'(model_tc(d) && en[d] && m_halt[d] == 0));
        end
    endtask

    // Inputs are already applied; check combinational outputs, take one edge, check registers.
    task automatic tick();
        #1;
        check_comb();
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_edge(d);
        #1;
        check_regs();
    endtask

    task automatic mid_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_regs();
        check_comb();
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int up_seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

        rst = 1'b0;
        set_all(0, 1, 0, 0, 0, 0);
        model_reset();
        #12;
        check_regs();
        check_comb();
        rst = 1'b1;

        // Asynchronous reset mid-cycle at count 7, then resume counting.
        set_all(0, 1, 0, 0, 1, 7);
        tick();
        set_all(1, 1, 0, 0, 0, 0);
        mid_reset();
        tick();
        check("resume_after_reset", 32'(count[0]), 32'd1);

        // Up wrap from 0 over 12 edges.
        set_all(0, 1, 0, 1, 0, 0);
        tick();
        set_all(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("up_seq[%0d]", i), 32'(count[0]), 32'(up_seq[i]));
        end

        // Down wrap, then direction change at 8.
        set_all(0, 0, 0, 0, 1, 2);
        tick();
        set_all(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        check("down_at_8", 32'(count[0]), 32'd8);
        set_all(1, 1, 0, 0, 0, 0);
        tick();
        tick();
        check("dir_change_to_0", 32'(count[0]), 32'd0);

        // Load range and priority.
        set_all(0, 1, 0, 0, 1, 12);
        tick();
        check("load_over_count", 32'(count[0]), 32'd9);
        check("load_over_err", 32'(err[0]), 32'd1);
        set_all(0, 1, 0, 1, 1, 5);
        tick();
        set_all(1, 1, 0, 0, 1, 3);
        tick();
        check("load_beats_en", 32'(count[0]), 32'd3);

        // One-shot halt and release by load.
        set_all(0, 1, 1, 0, 1, 7);
        tick();
        set_all(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        check("oneshot_hold", 32'(count[0]), 32'd9);
        check("oneshot_halted", 32'(halted[0]), 32'd1);
        set_all(1, 1, 0, 0, 0, 0);
        tick();
        set_all(0, 1, 1, 0, 1, 0);
        tick();
        mid_reset();

        // Full-range modulus wrap in both directions.
        set_all(0, 1, 0, 0, 1, 15);
        tick();
        set_all(1, 1, 0, 0, 0, 0);
        tick();
        check("m16_up_wrap", 32'(count[1]), 32'd0);
        set_all(1, 0, 0, 0, 0, 0);
        tick();
        check("m16_down_wrap", 32'(count[1]), 32'd15);

        // Randomised traffic, independent per instance.
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < 2; d++) begin
                clr[d]      = ($urandom_range(0, 19) == 0);
                load[d]     = ($urandom_range(0, 9) == 0);
                en[d]       = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) up[d] = ~up[d];
                if ($urandom_range(0, 15) == 0) oneshot[d] = ~oneshot[d];
                load_val[d] = W'($urandom_range(0, 15));
            end
            tick();
            if ($urandom_range(0, 63) == 0) mid_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised synchronous up/down counter. Successor to the fixed 4-bit toggle-flop counter.
- Adds configurable width and modulus, direction control, count enable, parallel load, synchronous clear, one-shot (halt-at-terminal) mode, terminal-count/carry outputs and a sticky load-range error flag.
- Used as the general-purpose counter/timer primitive in lab datapaths: dividers, sequencers and BCD digit chains via carry_out.

Parameters:
- WIDTH, 4: counter register width in bits.
- MODULUS, 16: count range is 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH; elaboration error otherwise.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low; rst=0 forces reset immediately, independent of clk.
- en  input  1  count enable; advances one step per clock when high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- oneshot  input  1  1 = halt at terminal value instead of wrapping.
- clr  input  1  synchronous clear to 0; also clears err.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  current count (registered).
- tc  output  1  terminal count, combinational: count==MODULUS-1 when up=1, count==0 when up=0.
- carry_out  output  1  tc & en & ~halted; cascade enable for the next stage.
- halted  output  1  registered; 1 when in oneshot mode and terminal reached.
- err  output  1  sticky registered flag: a load with load_val >= MODULUS occurred.

Behaviour:
- Reset: rst=0 asynchronously sets count=0, halted=0, err=0. tc reflects count=0 combinationally (tc=1 if up=0). Counting resumes on the first rising edge after rst returns high.
- Per-edge priority (rst high): clr > load > en.
- clr=1: count<=0, halted<=0, err<=0.
- load=1 (clr=0):
  - load_val < MODULUS: count<=load_val.
  - load_val >= MODULUS: count<=MODULUS-1, err<=1.
  - In both cases halted<=0.
- en=1 (clr=0, load=0, halted=0):
  - up=1: count<=count+1, or 0 when count==MODULUS-1.
  - up=0: count<=count-1, or MODULUS-1 when count==0.
- One-shot mode: if oneshot=1 and tc=1 and en=1, count is held and halted<=1. There is no wrap and carry_out still pulses for that cycle.
- While halted=1, en is ignored; only clr, load or rst release it.
- oneshot=0 never sets halted. Deasserting oneshot while halted does not clear halted.
- en=0 with no clr/load: all state held.
- Latency: count changes on the edge where the condition is sampled. tc and carry_out are combinational from count/up/en in the same cycle.
- Direction change mid-count takes effect on the next enabled edge from the current value; no skip or double-step.
- Arithmetic is modulo MODULUS, never modulo 2**WIDTH. Count values >= MODULUS are unreachable.
- MODULUS == 2**WIDTH: wrap compare must still use the explicit terminal value.
- Reset asserted mid-count or while halted: immediate return to 0; no edge required.

Decomposition:
- Shared package counter_pkg:
  - function term_value(up) returning MODULUS-1 or 0.
  - localparam MAXV = MODULUS-1.
  - range-check macro for MODULUS legality.
- One natural sub-module: mod_step. Combinational next-value unit taking count, up and MODULUS; outputs next count and wrap indication. It is instantiated once; the top holds the priority mux, halted/err registers and output logic.

Test Plan (WIDTH=4, MODULUS=10 unless noted):
- Reset/async: rst=0 mid-cycle at count=7 -> count=0, halted=0, err=0 before next clk edge. Release with en=1, up=1 -> 1 after first edge.
- Up wrap: en=1, up=1 from 0 for 12 edges -> sequence 1..9,0,1,2. tc=1 and carry_out=1 exactly while count=9.
- Down wrap/direction change: load 2, up=0, en=1 -> 1,0,9,8. Set up=1 at count=8 -> 9,0.
- Load range/priority: load_val=12 -> count=9, err=1. load and clr together -> count=0, err=0. load and en together with load_val=3 -> count=3.
- One-shot: oneshot=1, up=1, load 7, en=1 -> 8,9, then held at 9 with halted=1. carry_out pulses one cycle. load 0 releases halted.
- Full-range modulus (WIDTH=4, MODULUS=16): up from 15 -> 0. Down from 0 -> 15. err never set for any load_val.
